sap1_run_ctrl: RTL and testbench

Run/program sequencer for the SAP-1 core. It owns the 16x8 program RAM write port during program load and gates the CPU through a clock enable and a reset. It provides free-run, single-instruction step and halt handling. It sits between the front-panel inputs (mode, start, step, byte loader) and the CPU controller, RAM and clock-enable tree.

---
 rtl/sap1_run_ctrl.sv | 118 +++++++++++
 tb/tb_sap1_run_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sap1_run_ctrl.sv
// SAP-1 run/program sequencer: owns the program-RAM write port during load and
// gates the CPU through cpu_ce / cpu_rst for free run, single step and halt.
module sap1_run_ctrl #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int STEP_STATES = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode_prog,
    input  logic              start,
    input  logic              step,
    input  logic              halt_in,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              cpu_rst,
    output logic              cpu_ce,
    output logic              load_done,
    output logic [2:0]        state_out
);

    localparam int SC_W = (STEP_STATES > 1) ? $clog2(STEP_STATES) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RUN    = 3'd2,
        STEP   = 3'd3,
        PAUSE  = 3'd4,
        HALTED = 3'd5
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr_cnt;
    logic [SC_W-1:0]   step_cnt;
    logic              take;
    logic              last_word;
    logic              step_last;

    // Dropping mode_prog aborts the load, so a handshake in that cycle is not taken.
    assign take      = (state == LOAD) && mode_prog && load_valid;
    assign last_word = (addr_cnt == {ADDR_W{1'b1}});
    assign step_last = (step_cnt == SC_W'(STEP_STATES - 1));

    // NOTE: every variable in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_nx   = state;
        load_ready = 1'b0;
        cpu_rst    = 1'b0;
        cpu_ce     = 1'b0;
        unique case (state)
            IDLE: begin
                cpu_rst = 1'b1;
                if (mode_prog)  state_nx = LOAD;
                else if (start) state_nx = RUN;
                else if (step)  state_nx = STEP;
            end
            LOAD: begin
                cpu_rst    = 1'b1;
                load_ready = 1'b1;
                if (!mode_prog)             state_nx = IDLE;
                else if (take && last_word) state_nx = IDLE;
            end
            RUN: begin
                cpu_ce = 1'b1;
                if (halt_in)        state_nx = HALTED;
                else if (mode_prog) state_nx = LOAD;
            end
            STEP: begin
                cpu_ce = 1'b1;
                if (halt_in)        state_nx = HALTED;
                else if (step_last) state_nx = PAUSE;
            end
            PAUSE: begin
                if (mode_prog)  state_nx = LOAD;
                else if (start) state_nx = RUN;
                else if (step)  state_nx = STEP;
            end
            HALTED: begin
                if (mode_prog)  state_nx = LOAD;
                else if (start) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr_cnt  <= '0;
            step_cnt  <= '0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            load_done <= 1'b0;
        end else begin
            state     <= state_nx;
            ram_we    <= take;
            load_done <= take && last_word;
            if (take) begin
                ram_addr  <= addr_cnt;
                ram_wdata <= load_data;
            end
            if (state != LOAD && state_nx == LOAD) addr_cnt <= '0;
            else if (take)                          addr_cnt <= addr_cnt + 1'b1;
            if (state != STEP && state_nx == STEP) step_cnt <= '0;
            else if (state == STEP)                 step_cnt <= step_cnt + 1'b1;
        end
    end

    assign state_out = state;

endmodule

// File: tb/tb_sap1_run_ctrl.sv
// Self-checking bench for sap1_run_ctrl: RAM writes are scoreboarded, state and
// enable behaviour is checked inline per scenario.
module tb_sap1_run_ctrl;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int EXP_W  = ADDR_W + DATA_W + 1;

    logic              clk = 1'b0;
    logic              rst, mode_prog, start, step, halt_in, load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_ready, ram_we, cpu_rst, cpu_ce, load_done;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [2:0]        state_out;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;
    logic [EXP_W-1:0] sb[$];   // {addr, data, load_done}

    sap1_run_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STEP_STATES(6)) dut (
        .clk(clk), .rst(rst), .mode_prog(mode_prog), .start(start), .step(step),
        .halt_in(halt_in), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .cpu_rst(cpu_rst), .cpu_ce(cpu_ce),
        .load_done(load_done), .state_out(state_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string name, input logic [2:0] exp);
        checks++;
        if (state_out !== exp) begin
            failures++;
            $display("FAIL %s: state_out=%0d expected %0d", name, state_out, exp);
        end
    endtask

    task automatic expect_ctl(input string name, input logic exp_rst, input logic exp_ce);
        checks++;
        if (cpu_rst !== exp_rst || cpu_ce !== exp_ce) begin
            failures++;
            $display("FAIL %s: cpu_rst=%b cpu_ce=%b expected %b %b",
                     name, cpu_rst, cpu_ce, exp_rst, exp_ce);
        end
    endtask

    task automatic push_write(input int addr, input int data, input bit last);
        sb.push_back({ADDR_W'(addr), DATA_W'(data), last});
    endtask

    // Write monitor: every ram_we must match the oldest expected write.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (cpu_ce && cpu_rst) begin
                failures++;
                $display("FAIL ce_rst_exclusive: both asserted");
            end
            if (ram_we === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write: addr=%0d data=%h", ram_addr, ram_wdata);
                end else begin
                    logic [EXP_W-1:0] e;
                    e = sb.pop_front();
                    if ({ram_addr, ram_wdata, load_done} !== e) begin
                        failures++;
                        $display("FAIL ram_write: got addr=%0d data=%h done=%b expected addr=%0d data=%h done=%b",
                                 ram_addr, ram_wdata, load_done,
                                 e[EXP_W-1 -: ADDR_W], e[DATA_W:1], e[0]);
                    end
                end
            end else if (load_done !== 1'b0) begin
                checks++;
                failures++;
                $display("FAIL load_done_alone: load_done=%b without ram_we", load_done);
            end
        end
    end

    task automatic expect_sb_empty(input string name);
        tick();
        tick();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s: %0d expected writes never seen", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; mode_prog = 0; start = 0; step = 0; halt_in = 0;
        load_valid = 0; load_data = '0;
        tick();
        tick();
        rst = 1'b0;
        mon_en = 1'b1;
        expect_state("reset_state", 3'd0);
        expect_ctl("reset_ctl", 1'b1, 1'b0);
        checks++;
        if ({load_ready, ram_we, ram_addr, ram_wdata, load_done} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: ready=%b we=%b addr=%0d data=%h done=%b expected all 0",
                     load_ready, ram_we, ram_addr, ram_wdata, load_done);
        end
    endtask

    task automatic test_full_load();
        mode_prog = 1'b1;
        tick();
        expect_state("load_entry", 3'd1);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (load_ready !== 1'b1) begin
                failures++;
                $display("FAIL load_ready_byte%0d: load_ready=%b expected 1", i, load_ready);
            end
            load_valid = 1'b1;
            load_data  = DATA_W'(8'h10 + i);
            push_write(i, 8'h10 + i, i == 15);
            tick();
        end
        mode_prog  = 1'b0;
        load_valid = 1'b0;
        expect_state("load_complete_idle", 3'd0);
        checks++;
        if (load_ready !== 1'b0) begin
            failures++;
            $display("FAIL load_ready_after_done: load_ready=%b expected 0", load_ready);
        end
        expect_sb_empty("full_load_drain");
    endtask

    task automatic test_load_abort();
        int n;
        mode_prog = 1'b1;
        tick();
        n = 0;
        for (int j = 0; j < 9; j++) begin
            load_valid = (j % 2 == 0);
            load_data  = DATA_W'(8'hA0 + j);
            if (load_valid) begin
                push_write(n, 8'hA0 + j, 1'b0);
                n++;
            end
            tick();
        end
        // Abort with a byte still offered: it must not be written.
        mode_prog  = 1'b0;
        load_valid = 1'b1;
        load_data  = 8'hEE;
        tick();
        load_valid = 1'b0;
        expect_state("abort_idle", 3'd0);
        expect_sb_empty("abort_drain");
        mode_prog  = 1'b1;
        tick();
        load_valid = 1'b1;
        load_data  = 8'h5A;
        push_write(0, 8'h5A, 1'b0);
        tick();
        load_valid = 1'b0;
        mode_prog  = 1'b0;
        tick();
        expect_state("reload_idle", 3'd0);
        expect_sb_empty("reload_drain");
    endtask

    task automatic test_run_halt();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 0) expect_state("run_entry", 3'd2);
            expect_ctl($sformatf("run_cycle%0d", i), 1'b0, 1'b1);
            if (i == 19) halt_in = 1'b1;
            tick();
        end
        expect_state("halted", 3'd5);
        expect_ctl("halted_ctl", 1'b0, 1'b0);
        step = 1'b1;
        tick();
        step = 1'b0;
        expect_state("halted_ignores_step", 3'd5);
        halt_in = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_state("halted_start_idle", 3'd0);
        expect_ctl("halted_start_ctl", 1'b1, 1'b0);
    endtask

    task automatic do_step(input string name);
        int n;
        step = 1'b1;
        tick();
        step = 1'b0;
        n = 0;
        for (int k = 0; k < 20 && state_out === 3'd3; k++) begin
            expect_ctl($sformatf("%s_ce%0d", name, k), 1'b0, 1'b1);
            n++;
            tick();
        end
        checks++;
        if (n != 6) begin
            failures++;
            $display("FAIL %s_count: cpu_ce cycles=%0d expected 6", name, n);
        end
        expect_state({name, "_pause"}, 3'd4);
        expect_ctl({name, "_pause_ctl"}, 1'b0, 1'b0);
    endtask

    task automatic test_step();
        do_step("step1");
        do_step("step2");
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_state("pause_start_run", 3'd2);
        expect_ctl("pause_start_ctl", 1'b0, 1'b1);
        halt_in = 1'b1;
        tick();
        halt_in = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_state("step_back_idle", 3'd0);
    endtask

    task automatic test_priority();
        start = 1'b1; step = 1'b1;
        tick();
        start = 1'b0; step = 1'b0;
        expect_state("start_over_step", 3'd2);
        halt_in = 1'b1;
        tick();
        halt_in = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_state("prio_back_idle", 3'd0);
        mode_prog = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        expect_state("prog_over_start", 3'd1);
        mode_prog = 1'b0;
        tick();
        expect_state("prio_abort_idle", 3'd0);
    endtask

    task automatic test_reset_mid_op();
        mode_prog = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) begin
            load_valid = 1'b1;
            load_data  = DATA_W'(8'h30 + i);
            push_write(i, 8'h30 + i, 1'b0);
            tick();
        end
        load_data = 8'h37;
        rst = 1'b1;
        mode_prog = 1'b0;
        tick();
        rst = 1'b0;
        load_valid = 1'b0;
        expect_state("rst_mid_load_state", 3'd0);
        expect_ctl("rst_mid_load_ctl", 1'b1, 1'b0);
        checks++;
        if (ram_we !== 1'b0 || ram_addr !== '0) begin
            failures++;
            $display("FAIL rst_mid_load_ram: we=%b addr=%0d expected 0 0", ram_we, ram_addr);
        end
        expect_sb_empty("rst_mid_load_drain");
        mode_prog = 1'b1;
        tick();
        load_valid = 1'b1;
        load_data  = 8'h77;
        push_write(0, 8'h77, 1'b0);
        tick();
        load_valid = 1'b0;
        mode_prog  = 1'b0;
        expect_sb_empty("post_rst_load_drain");
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        expect_state("mid_run", 3'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_state("rst_mid_run_state", 3'd0);
        expect_ctl("rst_mid_run_ctl", 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_load_abort();
        test_run_halt();
        test_step();
        test_priority();
        test_reset_mid_op();
        expect_sb_empty("final_drain");
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
